// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline stage.
//   NOP_INSTR : instruction word presented for bubbles and after reset
//   ctrl_t    : packed control vector carried alongside each instruction
//   data_t    : packed data vector carried alongside each instruction
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic       rf_wr;
        logic       csr_rf_wr;
        logic       csr_rf_rd;
        logic [1:0] wb_sel;
        logic [4:0] mem_op;
        logic [1:0] pad;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // rsvd is a spare lane so later fields can be added without changing
    // the width seen by every stage boundary.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] data_wr;
        logic [31:0] csr_wdata;
        logic [11:0] csr_addr;
        logic [31:0] rsvd;
    } data_t;

    localparam int DATA_W = $bits(data_t);

endpackage

// File: rtl/pipe_slot.sv
// One valid bit plus payload register.
//   clk, rst  : clock, async active-low reset
//   load_i    : capture d_i and set valid (wins over clear_i)
//   clear_i   : drop valid; payload is kept so out_data can hold its value
//   d_i       : payload in
//   valid_o   : slot holds an entry
//   q_o       : payload out
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] d_i,
    output logic         valid_o,
    output logic [W-1:0] q_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= d_i;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign q_o     = data_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register between two core stages (valid/ready).
//   clk, rst                      : clock, async active-low reset
//   flush                         : drop every held entry this cycle
//   in_valid/in_ready             : upstream handshake
//   in_instr/in_ctrl/in_data      : upstream payload
//   out_valid/out_ready           : downstream handshake
//   out_instr/out_ctrl/out_data   : head payload (instr/ctrl masked on bubbles)
//   occupancy                     : entries currently held (0..2)
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int          CTRL_W    = pipe_pkg::CTRL_W,
    parameter int          DATA_W    = pipe_pkg::DATA_W,
    parameter logic [31:0] NOP_INSTR = pipe_pkg::NOP_INSTR,
    parameter bit          SKID_EN   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    localparam int         PW      = 32 + CTRL_W + DATA_W;
    localparam logic [1:0] OCC_MAX = SKID_EN ? 2'd2 : 2'd1;

    logic [PW-1:0] in_pl;
    logic [PW-1:0] main_pl;
    logic [PW-1:0] main_d;
    logic [PW-1:0] skid_pl;
    logic          main_v;
    logic          skid_v;
    logic          main_load;
    logic          main_clear;
    logic          skid_load;
    logic          skid_clear;
    logic          accept;
    logic          retire;
    logic [1:0]    occ_q;
    logic [1:0]    occ_d;

    assign in_pl  = {in_instr, in_ctrl, in_data};
    assign accept = in_valid & in_ready & ~flush;
    assign retire = main_v & out_ready;

    // Skid only fills while the head is stalled, and in_ready is low while
    // it is full, so a retire never coincides with accept and a full skid.
    always_comb begin
        main_load  = 1'b0;
        main_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        main_d     = in_pl;
        if (flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else if (retire) begin
            if (skid_v) begin
                main_load  = 1'b1;
                main_d     = skid_pl;
                skid_clear = 1'b1;
            end else if (accept) begin
                main_load = 1'b1;
            end else begin
                main_clear = 1'b1;
            end
        end else if (accept) begin
            if (!main_v) begin
                main_load = 1'b1;
            end else begin
                skid_load = 1'b1;
            end
        end
    end

    pipe_slot #(.W(PW)) u_main (
        .clk     (clk),
        .rst     (rst),
        .load_i  (main_load),
        .clear_i (main_clear),
        .d_i     (main_d),
        .valid_o (main_v),
        .q_o     (main_pl)
    );

    generate
        if (SKID_EN) begin : g_skid
            pipe_slot #(.W(PW)) u_skid (
                .clk     (clk),
                .rst     (rst),
                .load_i  (skid_load),
                .clear_i (skid_clear),
                .d_i     (in_pl),
                .valid_o (skid_v),
                .q_o     (skid_pl)
            );
            // skid_v comes straight from a flop, so in_ready is registered.
            assign in_ready = ~skid_v;
        end else begin : g_noskid
            logic unused_skid;
            assign unused_skid = skid_load ^ skid_clear;
            assign skid_v      = 1'b0;
            assign skid_pl     = '0;
            assign in_ready    = ~main_v | out_ready;
        end
    endgenerate

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = 2'd0;
        end else begin
            case ({accept, retire})
                2'b10:   occ_d = occ_q + 2'd1;
                2'b01:   occ_d = occ_q - 2'd1;
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q <= 2'd0;
        end else begin
            occ_q <= occ_d;
        end
    end

    occ_range: assert property (@(posedge clk) disable iff (!rst) occ_q <= OCC_MAX);

    // Bubbles must never carry a live control word downstream.
    assign out_valid = main_v;
    assign out_instr = main_v ? main_pl[PW-1 -: 32] : NOP_INSTR;
    assign out_ctrl  = main_v ? main_pl[DATA_W +: CTRL_W] : '0;
    assign out_data  = main_pl[DATA_W-1:0];
    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
module tb_pipe_stage_elastic;
    import pipe_pkg::*;

    localparam int CW = pipe_pkg::CTRL_W;
    localparam int DW = pipe_pkg::DATA_W;
    localparam int PW = 32 + CW + DW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [31:0]   in_instr = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;

    logic          o_ready [2];
    logic          o_valid [2];
    logic [31:0]   o_instr [2];
    logic [CW-1:0] o_ctrl  [2];
    logic [DW-1:0] o_data  [2];
    logic [1:0]    o_occ   [2];

    // Reference model: per instance a FIFO of held entries (index 0 = head)
    // plus the last head data, which out_data keeps showing on bubbles.
    logic [PW-1:0] mfifo [2][2];
    int            mcnt  [2];
    logic [DW-1:0] mlast [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_elastic #(.SKID_EN(1'b1)) u_skid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(o_ready[0]),
        .in_instr(in_instr), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(o_valid[0]), .out_ready(out_ready),
        .out_instr(o_instr[0]), .out_ctrl(o_ctrl[0]), .out_data(o_data[0]),
        .occupancy(o_occ[0])
    );

    pipe_stage_elastic #(.SKID_EN(1'b0)) u_noskid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(o_ready[1]),
        .in_instr(in_instr), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(o_valid[1]), .out_ready(out_ready),
        .out_instr(o_instr[1]), .out_ctrl(o_ctrl[1]), .out_data(o_data[1]),
        .occupancy(o_occ[1])
    );

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_ready(input int k);
        if (k == 0) return mcnt[0] < 2;
        return (mcnt[1] == 0) || out_ready;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mcnt[k]  = 0;
            mlast[k] = '0;
        end
    endtask

    task automatic model_step();
        logic acc [2];
        logic ret [2];
        for (int k = 0; k < 2; k++) begin
            acc[k] = in_valid && exp_ready(k) && !flush;
            ret[k] = (mcnt[k] > 0) && out_ready;
        end
        for (int k = 0; k < 2; k++) begin
            if (flush) begin
                mcnt[k] = 0;
            end else begin
                if (ret[k]) begin
                    mfifo[k][0] = mfifo[k][1];
                    mcnt[k]--;
                end
                if (acc[k]) begin
                    mfifo[k][mcnt[k]] = {in_instr, in_ctrl, in_data};
                    mcnt[k]++;
                end
            end
            if (mcnt[k] > 0) mlast[k] = mfifo[k][0][DW-1:0];
        end
    endtask

    task automatic check_outputs(input string ctx);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_valid%0d", ctx, k), o_valid[k], mcnt[k] > 0);
            check($sformatf("%s_instr%0d", ctx, k), o_instr[k],
                  (mcnt[k] > 0) ? mfifo[k][0][PW-1 -: 32] : NOP_INSTR);
            check($sformatf("%s_ctrl%0d", ctx, k), o_ctrl[k],
                  (mcnt[k] > 0) ? mfifo[k][0][DW +: CW] : '0);
            check($sformatf("%s_data%0d", ctx, k), o_data[k], mlast[k]);
            check($sformatf("%s_occ%0d", ctx, k), o_occ[k], mcnt[k]);
        end
    endtask

    // Drive one cycle of inputs just after an edge, check the combinational
    // in_ready, then clock the model and check the registered outputs.
    task automatic cycle(input string ctx, input logic v, input logic [31:0] instr,
                         input logic fl, input logic ordy);
        logic [191:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        in_valid  = v;
        in_instr  = instr;
        in_ctrl   = r[CW-1:0];
        in_data   = r[DW+CW-1:CW];
        flush     = fl;
        out_ready = ordy;
        #1;
        for (int k = 0; k < 2; k++)
            check($sformatf("%s_inrdy%0d", ctx, k), o_ready[k], exp_ready(k));
        @(posedge clk);
        model_step();
        #1;
        check_outputs(ctx);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_outputs("reset");
        for (int k = 0; k < 2; k++) check($sformatf("reset_inrdy%0d", k), o_ready[k], 1'b1);
        @(posedge clk);
        #1;

        cycle("stream", 1'b1, 32'h00A0_0093, 1'b0, 1'b1);
        cycle("stream", 1'b1, 32'h00B0_0113, 1'b0, 1'b1);
        cycle("stream", 1'b1, 32'h00C0_0193, 1'b0, 1'b1);
        check("stream_occ_skid", o_occ[0], 2'd1);
        cycle("drain", 1'b0, 32'h0, 1'b0, 1'b1);

        cycle("stall", 1'b1, 32'h1111_1111, 1'b0, 1'b0);
        cycle("stall", 1'b1, 32'h2222_2222, 1'b0, 1'b0);
        check("stall_occ_skid", o_occ[0], 2'd2);
        check("stall_head_skid", o_instr[0], 32'h1111_1111);
        cycle("stall_hold", 1'b0, 32'h0, 1'b0, 1'b0);
        check("stall_inrdy_skid", o_ready[0], 1'b0);
        cycle("release", 1'b0, 32'h0, 1'b0, 1'b1);
        check("release_headB", o_instr[0], 32'h2222_2222);
        check("release_inrdy", o_ready[0], 1'b1);
        cycle("release", 1'b0, 32'h0, 1'b0, 1'b1);

        cycle("fill", 1'b1, 32'h4444_4444, 1'b0, 1'b0);
        cycle("fill", 1'b1, 32'h5555_5555, 1'b0, 1'b0);
        cycle("flush", 1'b1, 32'h3333_3333, 1'b1, 1'b0);
        check("flush_instr_skid", o_instr[0], NOP_INSTR);
        check("flush_occ_skid", o_occ[0], 2'd0);
        for (int i = 0; i < 3; i++) begin
            cycle("postflush", 1'b0, 32'h0, 1'b0, 1'b1);
            check("postflush_no33", o_instr[0] == 32'h3333_3333, 1'b0);
        end

        cycle("bp", 1'b1, 32'h6666_6666, 1'b0, 1'b0);
        cycle("bp", 1'b1, 32'h7777_7777, 1'b0, 1'b0);
        check("bp_inrdy_noskid", o_ready[1], 1'b0);
        cycle("bp_swap", 1'b1, 32'h8888_8888, 1'b0, 1'b1);
        check("bp_occ_noskid", o_occ[1], 2'd1);
        cycle("bp_drain", 1'b0, 32'h0, 1'b0, 1'b1);
        cycle("bp_drain", 1'b0, 32'h0, 1'b0, 1'b1);

        cycle("arst", 1'b1, 32'h9999_9999, 1'b0, 1'b0);
        cycle("arst", 1'b1, 32'hAAAA_AAAA, 1'b0, 1'b0);
        check("arst_occ_pre", o_occ[0], 2'd2);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_outputs("arst");
        for (int k = 0; k < 2; k++) check($sformatf("arst_inrdy%0d", k), o_ready[k], 1'b1);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 500; i++) begin
            cycle("rand", ($urandom_range(0, 9) < 7), $urandom,
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 6));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
